isqrt_arbiter: RTL and testbench

ISQRT_ARBITER -- requirements
Module: isqrt_arbiter

---
 rtl/isqrt_arbiter_if.sv | 27 ++
 rtl/isqrt_arbiter.sv | 101 ++++++++++
 tb/tb_isqrt_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isqrt_arbiter_if.sv
// Client request/response and isqrt-side signals for the isqrt arbiter.
interface isqrt_arbiter_if #(
  parameter int unsigned N_CLIENTS = 4
);
  logic [N_CLIENTS-1:0]    req_vld;
  logic [N_CLIENTS*32-1:0] req_x;
  logic [N_CLIENTS-1:0]    req_rdy;
  logic [N_CLIENTS-1:0]    rsp_vld;
  logic [15:0]             rsp_y;
  logic                    isqrt_x_vld;
  logic [31:0]             isqrt_x;
  logic                    isqrt_y_vld;
  logic [15:0]             isqrt_y;
  logic                    err;

  // Environment side: clients plus the isqrt unit.
  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, err
  );

  // Arbiter side.
  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x, err
  );
endinterface

// File: rtl/isqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined in-order isqrt unit among
// N_CLIENTS requesters; a tag FIFO routes each result back to its issuer.
module isqrt_arbiter #(
  parameter int unsigned N_CLIENTS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         rst,
  isqrt_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]     last_granted;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [IDX_W-1:0]     tag_mem [MAX_OUTSTANDING];
  logic [N_CLIENTS-1:0] rsp_vld_q;
  logic [15:0]          rsp_y_q;
  logic                 err_q;

  logic [N_CLIENTS-1:0] grant_c;
  logic [IDX_W-1:0]     grant_idx_c;
  logic                 found_c;
  logic                 issue_c;
  logic                 pop_c;
  logic                 stray_c;

  // Round-robin search starting just after the last granted client.
  always_comb begin
    int unsigned cand;
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    cand        = 0;
    if (!rst && (count < CNT_W'(MAX_OUTSTANDING))) begin
      for (int unsigned k = 1; k <= N_CLIENTS; k++) begin
        cand = (32'(last_granted) + k) % N_CLIENTS;
        if (!found_c && bus.req_vld[IDX_W'(cand)]) begin
          found_c     = 1'b1;
          grant_idx_c = IDX_W'(cand);
        end
      end
      if (found_c) grant_c[grant_idx_c] = 1'b1;
    end
  end

  // A result with nothing outstanding is a stray: flagged, never popped.
  always_comb begin
    issue_c = |grant_c;
    pop_c   = bus.isqrt_y_vld && (count != '0);
    stray_c = bus.isqrt_y_vld && (count == '0);
  end

  assign bus.req_rdy     = grant_c;
  assign bus.isqrt_x_vld = issue_c;
  assign bus.isqrt_x     = bus.req_x[32*int'(grant_idx_c) +: 32];
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_y       = rsp_y_q;
  assign bus.err         = err_q;

  // Tag storage; contents are meaningless outside the valid window, so no reset.
  always_ff @(posedge clk) begin
    if (issue_c) tag_mem[wr_ptr] <= grant_idx_c;
  end

  // Arbitration, occupancy, pointer and response state.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_granted <= IDX_W'(N_CLIENTS - 1);
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rsp_vld_q    <= '0;
      rsp_y_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      if (issue_c) begin
        last_granted <= grant_idx_c;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop_c) begin
        rsp_vld_q <= N_CLIENTS'(1) << tag_mem[rd_ptr];
        rsp_y_q   <= bus.isqrt_y;
      end else begin
        rsp_vld_q <= '0;
      end
      if (stray_c) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed and randomized checks of the isqrt arbiter with a behavioural
// in-order isqrt model of random latency.
module tb_isqrt_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  isqrt_arbiter_if #(.N_CLIENTS(4)) bus ();

  isqrt_arbiter #(.N_CLIENTS(4), .MAX_OUTSTANDING(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'(1) << b);
      if (({16'b0, t} * {16'b0, t}) <= x) r = t;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.req_vld     = '0;
    bus.isqrt_y_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.req_vld = 4'hF;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0000 || bus.isqrt_x_vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdy: req_rdy=%b isqrt_x_vld=%b required 0000/0", bus.req_rdy, bus.isqrt_x_vld);
    end
    @(negedge clk);
    tests++;
    if (bus.rsp_vld !== 4'b0000 || bus.rsp_y !== 16'd0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: rsp_vld=%b rsp_y=%0d err=%b required 0000/0/0", bus.rsp_vld, bus.rsp_y, bus.err);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL reset_priority: req_rdy=%b required 0001", bus.req_rdy);
    end
    bus.req_vld = '0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_vld       = 4'b0100;
    bus.req_x[64 +: 32] = 32'd144;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0100 || bus.isqrt_x_vld !== 1'b1 || bus.isqrt_x !== 32'd144) begin
      fails++;
      $display("FAIL single_issue: req_rdy=%b x_vld=%b x=%0d required 0100/1/144", bus.req_rdy, bus.isqrt_x_vld, bus.isqrt_x);
    end
    @(negedge clk);
    bus.req_vld     = '0;
    bus.isqrt_y_vld = 1'b1;
    bus.isqrt_y     = 16'd12;
    @(negedge clk);
    bus.isqrt_y_vld = 1'b0;
    tests++;
    if (bus.rsp_vld !== 4'b0100 || bus.rsp_y !== 16'd12) begin
      fails++;
      $display("FAIL single_rsp: rsp_vld=%b rsp_y=%0d required 0100/12", bus.rsp_vld, bus.rsp_y);
    end
    @(negedge clk);
    tests++;
    if (bus.rsp_vld !== 4'b0000 || bus.rsp_y !== 16'd12 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: rsp_vld=%b rsp_y=%0d err=%b required 0000/12/0", bus.rsp_vld, bus.rsp_y, bus.err);
    end
  endtask

  task automatic test_round_robin();
    int          order [5];
    logic [15:0] ys [4];
    order = '{0, 1, 2, 3, 0};
    ys    = '{16'd10, 16'd20, 16'd30, 16'd40};
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_x[32*i +: 32] = 32'(ys[i]) * 32'(ys[i]);
    bus.req_vld = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (bus.req_rdy !== 4'(1 << order[k]) || bus.isqrt_x !== 32'(ys[order[k]]) * 32'(ys[order[k]])) begin
        fails++;
        $display("FAIL rr_grant%0d: req_rdy=%b x=%0d required %b", k, bus.req_rdy, bus.isqrt_x, 4'(1 << order[k]));
      end
      @(negedge clk);
    end
    bus.req_vld = '0;
    for (int k = 0; k < 5; k++) begin
      bus.isqrt_y_vld = 1'b1;
      bus.isqrt_y     = ys[order[k]];
      @(negedge clk);
      tests++;
      if (bus.rsp_vld !== 4'(1 << order[k]) || bus.rsp_y !== ys[order[k]]) begin
        fails++;
        $display("FAIL rr_rsp%0d: rsp_vld=%b rsp_y=%0d required %b/%0d", k, bus.rsp_vld, bus.rsp_y, 4'(1 << order[k]), ys[order[k]]);
      end
    end
    bus.isqrt_y_vld = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_x[32*i +: 32] = 32'(i + 50);
    bus.req_vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++;
      if (bus.req_rdy !== 4'(1 << (k % 4))) begin
        fails++;
        $display("FAIL full_fill%0d: req_rdy=%b required %b", k, bus.req_rdy, 4'(1 << (k % 4)));
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (bus.req_rdy !== 4'b0000 || bus.isqrt_x_vld !== 1'b0) begin
        fails++;
        $display("FAIL full_block%0d: req_rdy=%b x_vld=%b required 0000/0", k, bus.req_rdy, bus.isqrt_x_vld);
      end
      @(negedge clk);
    end
    bus.isqrt_y_vld = 1'b1;
    bus.isqrt_y     = 16'd7;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL full_pop_same: req_rdy=%b required 0000", bus.req_rdy);
    end
    @(negedge clk);
    bus.isqrt_y_vld = 1'b0;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0001 || bus.rsp_vld !== 4'b0001 || bus.rsp_y !== 16'd7) begin
      fails++;
      $display("FAIL full_resume: req_rdy=%b rsp_vld=%b rsp_y=%0d required 0001/0001/7", bus.req_rdy, bus.rsp_vld, bus.rsp_y);
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL full_refill: req_rdy=%b required 0000", bus.req_rdy);
    end
    bus.req_vld = '0;
  endtask

  task automatic test_stray();
    do_reset();
    bus.isqrt_y_vld = 1'b1;
    bus.isqrt_y     = 16'd5;
    @(negedge clk);
    bus.isqrt_y_vld = 1'b0;
    tests++;
    if (bus.err !== 1'b1 || bus.rsp_vld !== 4'b0000) begin
      fails++;
      $display("FAIL stray_err: err=%b rsp_vld=%b required 1/0000", bus.err, bus.rsp_vld);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.err !== 1'b1 || bus.rsp_vld !== 4'b0000 || bus.rsp_y !== 16'd0) begin
      fails++;
      $display("FAIL stray_sticky: err=%b rsp_vld=%b rsp_y=%0d required 1/0000/0", bus.err, bus.rsp_vld, bus.rsp_y);
    end
    bus.req_vld = 4'hF;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL stray_count: req_rdy=%b required 0001", bus.req_rdy);
    end
    bus.req_vld = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL mid_err_clear: err=%b required 0", bus.err);
    end
    bus.req_vld = 4'hF;
    repeat (3) @(negedge clk);
    bus.req_vld = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.rsp_vld !== 4'b0000 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL mid_regs: rsp_vld=%b err=%b required 0000/0", bus.rsp_vld, bus.err);
    end
    bus.req_vld = 4'hF;
    #1;
    tests++;
    if (bus.req_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL mid_priority: req_rdy=%b required 0001", bus.req_rdy);
    end
    bus.req_vld     = '0;
    bus.isqrt_y_vld = 1'b1;
    bus.isqrt_y     = 16'd9;
    @(negedge clk);
    bus.isqrt_y_vld = 1'b0;
    tests++;
    if (bus.err !== 1'b1 || bus.rsp_vld !== 4'b0000) begin
      fails++;
      $display("FAIL mid_late: err=%b rsp_vld=%b required 1/0000", bus.err, bus.rsp_vld);
    end
    bus.req_vld = 4'hF;
    for (int k = 0; k < 9; k++) begin
      #1;
      tests++;
      if ((k < 8 && bus.req_rdy === 4'b0000) || (k == 8 && bus.req_rdy !== 4'b0000)) begin
        fails++;
        $display("FAIL mid_count%0d: req_rdy=%b", k, bus.req_rdy);
      end
      @(negedge clk);
    end
    bus.req_vld = '0;
  endtask

  typedef struct {
    int          cyc;
    int          client;
    logic [15:0] y;
  } inflight_t;

  task automatic test_stress();
    inflight_t   q[$];
    inflight_t   e;
    logic [3:0]  pend;
    logic [31:0] px [4];
    int          sent [4];
    int          got [4];
    bit          exp_rsp;
    int          exp_c;
    logic [15:0] exp_y;
    int          last_ready;
    int          cnt_before;
    int          idx;
    bit          drained;
    pend       = '0;
    exp_rsp    = 1'b0;
    exp_c      = 0;
    exp_y      = '0;
    last_ready = 0;
    drained    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      got[i]  = 0;
      px[i]   = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 2400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      tests++;
      if (exp_rsp) begin
        if (bus.rsp_vld !== 4'(1 << exp_c) || bus.rsp_y !== exp_y) begin
          fails++;
          $display("FAIL stress_rsp cyc%0d: rsp_vld=%b rsp_y=%0d required %b/%0d", cyc, bus.rsp_vld, bus.rsp_y, 4'(1 << exp_c), exp_y);
        end else begin
          got[exp_c]++;
        end
      end else if (bus.rsp_vld !== 4'b0000) begin
        fails++;
        $display("FAIL stress_idle cyc%0d: rsp_vld=%b required 0000", cyc, bus.rsp_vld);
      end
      if (cyc >= 2000 && q.size() == 0 && pend == 4'b0000) begin
        drained = 1'b1;
        break;
      end
      if (cyc < 2000) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
            pend[i] = 1'b1;
            px[i]   = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 100)) : $urandom);
          end
        end
      end
      bus.req_vld = pend;
      for (int i = 0; i < 4; i++) bus.req_x[32*i +: 32] = px[i];
      cnt_before = q.size();
      exp_rsp    = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e               = q.pop_front();
        bus.isqrt_y_vld = 1'b1;
        bus.isqrt_y     = e.y;
        exp_rsp         = 1'b1;
        exp_c           = e.client;
        exp_y           = e.y;
      end else begin
        bus.isqrt_y_vld = 1'b0;
        bus.isqrt_y     = 16'($urandom);
      end
      #1;
      tests++;
      if ($countones(bus.req_rdy) > 1 || (bus.req_rdy & ~pend) != 4'b0000 ||
          (|bus.req_rdy) !== ((|pend) && cnt_before < 8) || bus.isqrt_x_vld !== (|bus.req_rdy)) begin
        fails++;
        $display("FAIL stress_grant cyc%0d: req_rdy=%b x_vld=%b with req_vld=%b outstanding=%0d", cyc, bus.req_rdy, bus.isqrt_x_vld, pend, cnt_before);
      end
      if (|bus.req_rdy) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (bus.req_rdy[i]) idx = i;
        tests++;
        if (bus.isqrt_x !== px[idx]) begin
          fails++;
          $display("FAIL stress_x cyc%0d: isqrt_x=%h required %h", cyc, bus.isqrt_x, px[idx]);
        end
        e.client = idx;
        e.y      = ref_isqrt(px[idx]);
        e.cyc    = cyc + $urandom_range(1, 10);
        if (e.cyc <= last_ready) e.cyc = last_ready + 1;
        last_ready = e.cyc;
        q.push_back(e);
        pend[idx] = 1'b0;
        sent[idx]++;
      end
    end
    bus.req_vld     = '0;
    bus.isqrt_y_vld = 1'b0;
    tests++;
    if (!drained) begin
      fails++;
      $display("FAIL stress_drain: outstanding=%0d pending=%b required 0/0000", q.size(), pend);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] != sent[i] || sent[i] == 0) begin
        fails++;
        $display("FAIL stress_count client%0d: delivered=%0d issued=%0d", i, got[i], sent[i]);
      end
    end
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL stress_err: err=%b required 0", bus.err);
    end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rst             = 1'b1;
    bus.req_vld     = '0;
    bus.req_x       = '0;
    bus.isqrt_y_vld = 1'b0;
    bus.isqrt_y     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_stray();
    test_reset_mid();
    test_stress();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
